// File: rtl/modex_stream_engine.sv
// Constant-time modular exponentiation, result = base^exponent mod modulus, with valid/ready
// on operands and results. Latency 1+(EXP_W+1)*(WIDTH+1)+1 cycles (2 for modulus 0/1); result held under out_ready=0.

module modex_modmul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc
);
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH+1:0] m_ext, acc_base, sum, sub1, sub2;

    // acc < m on entry, so 2*acc + b < 3m and two conditional subtractions restore acc < m
    always_comb begin
        m_ext    = {2'b00, m};
        acc_base = clr ? '0 : acc_q;
        sum      = (acc_base << 1) + (a_bit ? {2'b00, b} : '0);
        sub1     = (sum >= m_ext) ? sum - m_ext : sum;
        sub2     = (sub1 >= m_ext) ? sub1 - m_ext : sub1;
        acc_d    = en ? sub2 : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

    assign acc = acc_q[WIDTH-1:0];
endmodule

module modex_stream_engine #(
    parameter int WIDTH = 16,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = $clog2(EXP_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REDUCE,
        S_EXP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic             step_en, step_clr, last_cnt;
    logic [WIDTH-1:0] mul_a, mul_b, a_sh, s_sh;
    logic [WIDTH-1:0] prod_a, prod_s;

    // Unit A forms base*1 during REDUCE and R*B during EXP; unit S forms B*B
    always_comb begin
        last_cnt = (cnt_q == CW'(WIDTH));
        step_en  = (state_q == S_REDUCE || state_q == S_EXP) && !last_cnt;
        step_clr = (cnt_q == '0);
        mul_a    = (state_q == S_REDUCE) ? base_q : r_q;
        mul_b    = (state_q == S_REDUCE) ? WIDTH'(1) : b_q;
        a_sh     = mul_a << cnt_q;
        s_sh     = b_q << cnt_q;
    end

    modex_modmul #(.WIDTH(WIDTH)) u_mul_rb (
        .clk   (clk),
        .rst   (rst),
        .clr   (step_clr),
        .en    (step_en),
        .a_bit (a_sh[WIDTH-1]),
        .b     (mul_b),
        .m     (mod_q),
        .acc   (prod_a)
    );

    modex_modmul #(.WIDTH(WIDTH)) u_mul_bb (
        .clk   (clk),
        .rst   (rst),
        .clr   (step_clr),
        .en    (step_en && state_q == S_EXP),
        .a_bit (s_sh[WIDTH-1]),
        .b     (b_q),
        .m     (mod_q),
        .acc   (prod_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        base_d      = base_q;
        exp_d       = exp_q;
        mod_d       = mod_q;
        r_d         = r_q;
        b_d         = b_q;
        result_d    = result_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d     = base;
                    exp_d      = exponent;
                    mod_d      = modulus;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (mod_q == '0) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else if (mod_q == WIDTH'(1)) begin
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (last_cnt) begin
                    b_d     = prod_a;
                    r_d     = WIDTH'(1);
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_EXP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXP: begin
                if (last_cnt) begin
                    // R*B always runs; the exponent bit only gates its writeback
                    b_d   = prod_s;
                    r_d   = exp_q[0] ? prod_a : r_q;
                    exp_d = exp_q >> 1;
                    cnt_d = '0;
                    if (k_q == KW'(EXP_W - 1)) begin
                        result_d = exp_q[0] ? prod_a : r_q;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            mod_q       <= '0;
            r_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            mod_q       <= mod_d;
            r_q         <= r_d;
            b_q         <= b_d;
            result_q    <= result_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;
endmodule

// File: doc/modex_stream_engine.md
Name: modex_stream_engine

Overview:
- Parametrised modular-exponentiation engine: result = base^exponent mod modulus.
- Successor to the fixed 16-bit MODEX datapath used for RSA decryption of memory words.
- Generalised in operand width and exponent width; adds a valid/ready operand handshake and a result handshake with backpressure.
- Adds constant-time execution, independent of exponent value, plus a degenerate-modulus error flag.
- Sits between the ciphertext memory reader and the plaintext sink.

Parameters:
- WIDTH, 16, bit width of base, modulus and result (>=4).
- EXP_W, 16, bit width of exponent (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  engine can accept operands.
- base  input  WIDTH  base operand; any value, including >= modulus.
- exponent  input  EXP_W  exponent operand.
- modulus  input  WIDTH  modulus operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  base^exponent mod modulus.
- err  output  1  qualified by out_valid; 1 when modulus == 0.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, in_ready=1, out_valid=0, result=0, err=0, busy=0, all internal registers cleared. Reset mid-computation aborts the computation; no result is emitted after release.
- Accept: the operand triple is accepted on a rising edge with in_valid && in_ready, and all three operands are registered then. in_ready is 1 only in IDLE.
- Modmul unit, interleaved shift-add, MSB-first over multiplier a; b < m is required:
  - Per cycle: acc = 2*acc + (a[i] ? b : 0), then subtract m while acc >= m (at most twice).
  - acc is WIDTH+2 bits; one multiplier bit per cycle; WIDTH cycles plus 1 writeback cycle = WIDTH+1 cycles per multiply.
- Two modmul units run in parallel: R*B and B*B.
- States:
  - IDLE: on accept, go to CHECK.
  - CHECK (1 cycle):
    - modulus==0: result=0, err=1, go to DONE.
    - modulus==1: result=0, err=0, go to DONE.
    - otherwise: go to REDUCE.
  - REDUCE (WIDTH+1 cycles): B = base*1 mod m; R = 1; bit index k = 0.
  - EXP (EXP_W*(WIDTH+1) cycles): right-to-left square-and-multiply, one step per exponent bit from LSB.
    - Each step: B <= B*B mod m; R <= exponent[k] ? R*B mod m : R, using the pre-square B.
    - The R*B product is always computed; only its writeback is masked.
    - All EXP_W bits are processed regardless of leading zeros (constant time).
  - DONE: out_valid=1; result and err held stable while out_valid && !out_ready. When out_valid && out_ready, go to IDLE with out_valid=0 and in_ready=1 on the next cycle.
- Latency, accept edge to first cycle with out_valid=1:
  - Normal path: 1 + (EXP_W+1)*(WIDTH+1) + 1 cycles. Defaults give 291.
  - Degenerate moduli: 2 cycles.
- exponent==0 with modulus>1 gives result=1.
- No overlap: the next operand is accepted no earlier than the cycle after the result handshake.
- in_valid while busy is ignored; the source must hold its operands until accepted.
- result is WIDTH bits and always < modulus when err=0.

Test Plan:
- 4^13 mod 497 with back-to-back in_valid -> result=445; out_valid exactly 291 cycles after accept; in_ready=0 throughout.
- RSA toy key n=3233 (61*53), e=17, d=2753:
  - 65^17 mod 3233 -> 2790.
  - 2790^2753 mod 3233 -> 65.
  - Both have identical latency, 291 cycles.
- Base >= modulus: 3298^17 mod 3233 -> 2790. Edge case exponent 0: 5^0 mod 7 -> 1.
- Degenerate moduli:
  - modulus=0 -> err=1, result=0, out_valid 2 cycles after accept.
  - modulus=1 -> err=0, result=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> result/err stable, in_ready=0; release -> in_ready=1 next cycle; the next operand is accepted and correct.
- Reset: assert rst low 100 cycles into a computation -> all outputs at reset values immediately (async). After release, no stale out_valid; a new 4^13 mod 497 returns 445.
